seq_frame_checker: RTL and testbench

//  Serial frame checker: groups Din into non-overlapping frames of FRAME_LEN bits
//  and flags each frame that matches (Mode=0) or mismatches (Mode=1) a masked

---
 rtl/seq_frame_checker.sv | 136 +++++++++++++
 tb/tb_seq_frame_checker.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_checker.sv
// Serial frame checker: splits the Din stream into non-overlapping frames of
// FRAME_LEN bits. Each completed frame is compared against a masked pattern,
// and a registered ERR pulse is raised on a match (Mode=0) or on a mismatch
// (Mode=1). A sticky flag and a saturating error counter track the ERR pulses.
module seq_frame_checker #(
    parameter int FRAME_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Din_valid,
    input  logic                 Din,
    input  logic [FRAME_LEN-1:0] Pattern,
    input  logic [FRAME_LEN-1:0] Mask,
    input  logic                 Mode,
    input  logic                 Clear,
    output logic                 ERR,
    output logic                 Frame_done,
    output logic [FRAME_LEN-1:0] Last_frame,
    output logic                 Sticky_err,
    output logic [CNT_W-1:0]     Err_count
);

    localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(FRAME_LEN - 1);
    localparam logic [FRAME_LEN-1:0] FIRST_SEL = {1'b1, {(FRAME_LEN-1){1'b0}}};

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    logic [0:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [FRAME_LEN-1:0] shift_reg;
    logic [FRAME_LEN-1:0] pat_l;
    logic [FRAME_LEN-1:0] mask_l;
    logic                 mode_l;
    logic                 mis_acc;

    logic [FRAME_LEN-1:0] cur_pat;
    logic [FRAME_LEN-1:0] cur_mask;
    logic                 cur_mode;
    logic [FRAME_LEN-1:0] sel;
    logic                 bit_mis;
    logic                 mis_total;
    logic [FRAME_LEN-1:0] frame_full;
    logic                 consume;
    logic                 last_bit;
    logic                 flag;

    // Per-bit compare; the first bit of a frame uses the live Pattern/Mask/Mode
    // because they are latched on that same edge.
    always_comb begin
        cur_pat    = (idx == '0) ? Pattern : pat_l;
        cur_mask   = (idx == '0) ? Mask    : mask_l;
        cur_mode   = (idx == '0) ? Mode    : mode_l;
        sel        = FIRST_SEL >> idx;
        bit_mis    = |(sel & cur_mask & (cur_pat ^ {FRAME_LEN{Din}}));
        mis_total  = mis_acc | bit_mis;
        frame_full = {shift_reg[FRAME_LEN-2:0], Din};
        consume    = (state == COLLECT) && Enable && Din_valid;
        last_bit   = consume && (idx == LAST_IDX);
        flag       = last_bit && (cur_mode ? mis_total : ~mis_total);
    end

    // FSM, frame collection and the registered per-frame result pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            idx        <= '0;
            shift_reg  <= '0;
            pat_l      <= '0;
            mask_l     <= '0;
            mode_l     <= 1'b0;
            mis_acc    <= 1'b0;
            ERR        <= 1'b0;
            Frame_done <= 1'b0;
            Last_frame <= '0;
        end else begin
            ERR        <= 1'b0;
            Frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    idx     <= '0;
                    mis_acc <= 1'b0;
                    if (Enable) state <= COLLECT;
                end
                COLLECT: begin
                    if (!Enable) begin
                        state     <= IDLE;
                        idx       <= '0;
                        mis_acc   <= 1'b0;
                        shift_reg <= '0;
                    end else if (Din_valid) begin
                        shift_reg <= frame_full;
                        if (idx == '0) begin
                            pat_l  <= Pattern;
                            mask_l <= Mask;
                            mode_l <= Mode;
                        end
                        if (last_bit) begin
                            idx        <= '0;
                            mis_acc    <= 1'b0;
                            Last_frame <= frame_full;
                            Frame_done <= 1'b1;
                            ERR        <= flag;
                        end else begin
                            idx     <= idx + IDX_W'(1);
                            mis_acc <= mis_total;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    idx     <= '0;
                    mis_acc <= 1'b0;
                end
            endcase
        end
    end

    // Status registers: Clear wins over a coincident flag; counter saturates.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Sticky_err <= 1'b0;
            Err_count  <= '0;
        end else if (Clear) begin
            Sticky_err <= 1'b0;
            Err_count  <= '0;
        end else if (flag) begin
            Sticky_err <= 1'b1;
            if (Err_count != '1) Err_count <= Err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_frame_checker.sv
// Self-checking bench for seq_frame_checker (FRAME_LEN=3, CNT_W=2).
// The reference model collects bits into a queue and judges whole frames.
module tb_seq_frame_checker;

    localparam int FL = 3;
    localparam int CW = 2;
    localparam int OW = 3 + FL + CW;

    logic          Clock;
    logic          Reset;
    logic          Enable;
    logic          Din_valid;
    logic          Din;
    logic [FL-1:0] Pattern;
    logic [FL-1:0] Mask;
    logic          Mode;
    logic          Clear;
    logic          ERR;
    logic          Frame_done;
    logic [FL-1:0] Last_frame;
    logic          Sticky_err;
    logic [CW-1:0] Err_count;

    int checks = 0;
    int errors = 0;

    seq_frame_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .Din_valid  (Din_valid),
        .Din        (Din),
        .Pattern    (Pattern),
        .Mask       (Mask),
        .Mode       (Mode),
        .Clear      (Clear),
        .ERR        (ERR),
        .Frame_done (Frame_done),
        .Last_frame (Last_frame),
        .Sticky_err (Sticky_err),
        .Err_count  (Err_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [OW-1:0] obs;
    assign obs = {ERR, Frame_done, Sticky_err, Last_frame, Err_count};

    // reference model state
    bit      m_active;
    int      m_bits[$];
    int      m_pat, m_mask, m_mode;
    int      e_err, e_done, e_sticky, e_last, e_cnt;
    logic [OW-1:0] exp_vec;

    function automatic logic [OW-1:0] pack_exp();
        return {e_err[0], e_done[0], e_sticky[0], e_last[FL-1:0], e_cnt[CW-1:0]};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_bits.delete();
        e_err = 0; e_done = 0; e_sticky = 0; e_last = 0; e_cnt = 0;
        exp_vec = pack_exp();
    endtask

    task automatic model_step(input bit en, input bit dv, input bit d, input bit clr);
        int frame, hit, flag;
        e_err  = 0;
        e_done = 0;
        flag   = 0;
        if (!m_active) begin
            if (en) m_active = 1;
        end else if (!en) begin
            m_active = 0;
            m_bits.delete();
        end else if (dv) begin
            if (m_bits.size() == 0) begin
                m_pat  = int'(Pattern);
                m_mask = int'(Mask);
                m_mode = int'(Mode);
            end
            m_bits.push_back(int'(d));
            if (m_bits.size() == FL) begin
                frame = 0;
                foreach (m_bits[i]) frame = frame * 2 + m_bits[i];
                hit    = (((frame ^ m_pat) & m_mask) == 0) ? 1 : 0;
                flag   = m_mode ? (1 - hit) : hit;
                e_done = 1;
                e_err  = flag;
                e_last = frame;
                m_bits.delete();
            end
        end
        if (clr) begin
            e_cnt = 0;
            e_sticky = 0;
        end else if (flag != 0) begin
            e_sticky = 1;
            if (e_cnt < (1 << CW) - 1) e_cnt = e_cnt + 1;
        end
        exp_vec = pack_exp();
    endtask

    // one clock: drive at negedge, predict, sample 1 ns after the rising edge
    task automatic step(input bit en, input bit dv, input bit d, input bit clr);
        @(negedge Clock);
        Enable = en; Din_valid = dv; Din = d; Clear = clr;
        model_step(en, dv, d, clr);
        @(posedge Clock);
        #1;
    endtask

    // reset asserted away from the clock edge; outputs must clear immediately
    task automatic pulse_reset(input string tag);
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s_async_clear got=%b exp=%b", tag, obs, {OW{1'b0}});
        end
        model_reset();
        @(negedge Clock);
        Enable = 0; Din_valid = 0; Din = 0; Clear = 0;
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Enable = 0; Din_valid = 0; Din = 0; Clear = 0;
        Pattern = '0; Mask = '0; Mode = 0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", obs, exp_vec);
        end
        @(negedge Clock);
        Reset = 1'b1;
        step(0, 0, 0, 0);
        checks++;
        if (obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=%b", obs, exp_vec);
        end
    endtask

    task automatic test_match_mismatch();
        bit seq [9] = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
        Pattern = 3'b111; Mask = 3'b111; Mode = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i == 6) Mode = 1;
            step(1, 1, seq[i], 0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL match_mismatch cyc=%0d got=%b exp=%b", i, obs, exp_vec);
            end
            if (i == 2) begin
                checks++;
                if ({ERR, Frame_done, Err_count, Last_frame} !== {1'b1, 1'b1, 2'd1, 3'b111}) begin
                    errors++;
                    $display("FAIL first_match got=%b exp=%b", {ERR, Frame_done, Err_count, Last_frame}, 7'b1101111);
                end
            end
            if (i == 5) begin
                checks++;
                if ({ERR, Frame_done, Last_frame} !== {1'b0, 1'b1, 3'b110}) begin
                    errors++;
                    $display("FAIL no_match got=%b exp=%b", {ERR, Frame_done, Last_frame}, 5'b01110);
                end
            end
            if (i == 8) begin
                checks++;
                if ({ERR, Sticky_err} !== 2'b11) begin
                    errors++;
                    $display("FAIL mode1_flag got=%b exp=%b", {ERR, Sticky_err}, 2'b11);
                end
            end
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_gaps();
        bit seq [3] = '{1, 0, 1};
        int n_err = 0;
        Pattern = 3'b111; Mask = 3'b101; Mode = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < 3; g++) begin
                step(1, (g == 0), seq[i], 0);
                if (ERR === 1'b1) n_err++;
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL gaps bit=%0d g=%0d got=%b exp=%b", i, g, obs, exp_vec);
                end
            end
        end
        checks++;
        if (n_err != 1) begin
            errors++;
            $display("FAIL gaps_err_count got=%0d exp=1", n_err);
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_saturate_clear();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        Pattern = 3'b101; Mask = 3'b111; Mode = 0;
        step(1, 0, 0, 1);
        for (int f = 0; f < 6; f++) begin
            for (int b = 0; b < 3; b++) begin
                step(1, 1, (b != 1), (f == 5 && b == 2));
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL saturate f=%0d b=%0d got=%b exp=%b", f, b, obs, exp_vec);
                end
            end
            if (f < 5) begin
                checks++;
                if (Err_count !== exp_cnt[f][CW-1:0]) begin
                    errors++;
                    $display("FAIL sat_count f=%0d got=%0d exp=%0d", f, Err_count, exp_cnt[f]);
                end
            end else begin
                checks++;
                if ({ERR, Sticky_err, Err_count} !== 4'b1000) begin
                    errors++;
                    $display("FAIL clear_priority got=%b exp=%b", {ERR, Sticky_err, Err_count}, 4'b1000);
                end
            end
        end
        step(0, 0, 0, 1);
    endtask

    task automatic test_abort_and_reset();
        // en, dv, d
        bit tbl [9][3] = '{'{1,0,0}, '{1,1,1}, '{1,1,1}, '{0,1,1}, '{1,0,0},
                           '{1,1,1}, '{1,1,1}, '{1,1,1}, '{1,0,0}};
        int n_done = 0;
        int done_at = -1;
        Pattern = 3'b111; Mask = 3'b111; Mode = 0;
        for (int i = 0; i < 9; i++) begin
            step(tbl[i][0], tbl[i][1], tbl[i][2], 0);
            if (Frame_done === 1'b1) begin
                n_done++;
                done_at = i;
            end
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL abort cyc=%0d got=%b exp=%b", i, obs, exp_vec);
            end
        end
        checks++;
        if (n_done != 1 || done_at != 7) begin
            errors++;
            $display("FAIL abort_done got=%0d@%0d exp=1@7", n_done, done_at);
        end
        // reset in the middle of a frame
        step(1, 1, 1, 0);
        step(1, 1, 0, 0);
        pulse_reset("midframe");
        step(0, 0, 0, 0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL after_reset got=%b exp=%b", obs, {OW{1'b0}});
        end
    endtask

    task automatic test_random();
        bit en, dv, d, clr;
        for (int i = 0; i < 600; i++) begin
            Pattern = FL'($urandom);
            Mask    = FL'($urandom);
            Mode    = 1'($urandom);
            en  = ($urandom_range(0, 15) != 0);
            dv  = ($urandom_range(0, 9) < 7);
            d   = 1'($urandom);
            clr = ($urandom_range(0, 19) == 0);
            step(en, dv, d, clr);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_match_mismatch();
        test_gaps();
        test_saturate_clear();
        test_abort_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
